// File: rtl/ctrl_seq_if.sv
// Signal bundle between the sequencer and the rest of the teaching CPU.
// master: the sequencer side. slave: the datapath/IO side.
interface ctrl_seq_if;
    logic        run;
    logic        mem_ready;
    logic [15:0] dec_op;
    logic        flag_z;
    logic        flag_c;
    logic        in_valid;
    logic        out_ready;
    logic        dec_en;
    logic        mem_rd;
    logic        ir_ld;
    logic        pc_inc;
    logic        pc_ld;
    logic        alu_go;
    logic        reg_we;
    logic        in_ack;
    logic        out_valid;
    logic        halted;
    logic        io_err;
    logic [2:0]  state;

    modport master (
        input  run, mem_ready, dec_op, flag_z, flag_c, in_valid, out_ready,
        output dec_en, mem_rd, ir_ld, pc_inc, pc_ld, alu_go, reg_we,
               in_ack, out_valid, halted, io_err, state
    );

    modport slave (
        output run, mem_ready, dec_op, flag_z, flag_c, in_valid, out_ready,
        input  dec_en, mem_rd, ir_ld, pc_inc, pc_ld, alu_go, reg_we,
               in_ack, out_valid, halted, io_err, state
    );
endinterface

// File: rtl/ctrl_seq.sv
// Hardwired fetch/decode/execute sequencer for the 8-bit teaching CPU.
// All strobes are decoded combinationally from the state, the latched
// opcode and the live inputs; only state, opcode, IO counter and the
// sticky IO error flag are registered.
module ctrl_seq #(
    parameter int IO_TO = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    ctrl_seq_if.master   bus
);
    // Opcode bit positions inside the one-hot decoder bus (bit15 = mova).
    localparam int OP_ALU_LO = 7;   // mova..rsl occupy bits 15..7
    localparam int OP_JMP    = 6;
    localparam int OP_JZ     = 5;
    localparam int OP_JC     = 4;
    localparam int OP_IN1    = 3;
    localparam int OP_OUT1   = 2;
    localparam int OP_NOP    = 1;
    localparam int OP_HALT   = 0;

    localparam int CW = (IO_TO > 2) ? $clog2(IO_TO) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXEC    = 3'd3,
        S_IO_WAIT = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    state_t        state_reg, state_next;
    logic [15:0]   op_reg, op_next;
    logic [CW-1:0] io_cnt_reg, io_cnt_next;
    logic          io_err_reg, io_err_next;
    logic [15:0]   dec_sel;

    logic dec_en, mem_rd, ir_ld, pc_inc, pc_ld, alu_go, reg_we;
    logic in_ack, out_valid, halted, io_done;

    // Keep only the highest set decoder line so op_reg is always one-hot.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_prio
            if (gi == 15) begin : g_top
                assign dec_sel[gi] = bus.dec_op[gi];
            end else begin : g_low
                assign dec_sel[gi] = bus.dec_op[gi] & ~(|bus.dec_op[15:gi+1]);
            end
        end
    endgenerate

    // State, latched opcode, IO wait counter and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            op_reg     <= '0;
            io_cnt_reg <= '0;
            io_err_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            io_cnt_reg <= io_cnt_next;
            io_err_reg <= io_err_next;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        io_cnt_next = io_cnt_reg;
        io_err_next = io_err_reg;
        dec_en      = 1'b0;
        mem_rd      = 1'b0;
        ir_ld       = 1'b0;
        pc_inc      = 1'b0;
        pc_ld       = 1'b0;
        alu_go      = 1'b0;
        reg_we      = 1'b0;
        in_ack      = 1'b0;
        out_valid   = 1'b0;
        halted      = 1'b0;
        io_done     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (bus.run) state_next = S_FETCH;
            end
            S_FETCH: begin
                mem_rd = 1'b1;
                ir_ld  = bus.mem_ready;
                pc_inc = bus.mem_ready;
                if (bus.mem_ready) state_next = S_DECODE;
            end
            S_DECODE: begin
                dec_en     = 1'b1;
                // An all-zero decode is an illegal opcode; run it as nop.
                op_next    = (bus.dec_op == 16'd0) ? 16'(1 << OP_NOP) : dec_sel;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                state_next = S_FETCH;
                if (|op_reg[15:OP_ALU_LO]) begin
                    alu_go = 1'b1;
                    reg_we = 1'b1;
                end
                pc_ld = op_reg[OP_JMP] | (op_reg[OP_JZ] & bus.flag_z)
                      | (op_reg[OP_JC] & bus.flag_c);
                if (op_reg[OP_IN1] | op_reg[OP_OUT1]) begin
                    io_cnt_next = '0;
                    state_next  = S_IO_WAIT;
                end
                if (op_reg[OP_HALT]) state_next = S_HALT;
            end
            S_IO_WAIT: begin
                if (op_reg[OP_IN1]) begin
                    in_ack  = bus.in_valid;
                    reg_we  = bus.in_valid;
                    io_done = bus.in_valid;
                end else begin
                    out_valid = 1'b1;
                    io_done   = bus.out_ready;
                end
                // A handshake on the last allowed cycle still completes.
                if (io_done) begin
                    state_next = S_FETCH;
                end else if (io_cnt_reg == CW'(IO_TO - 1)) begin
                    io_err_next = 1'b1;
                    state_next  = S_FETCH;
                end else begin
                    io_cnt_next = io_cnt_reg + 1'b1;
                end
            end
            S_HALT: begin
                halted = 1'b1;
                if (bus.run) state_next = S_FETCH;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign bus.dec_en    = dec_en;
    assign bus.mem_rd    = mem_rd;
    assign bus.ir_ld     = ir_ld;
    assign bus.pc_inc    = pc_inc;
    assign bus.pc_ld     = pc_ld;
    assign bus.alu_go    = alu_go;
    assign bus.reg_we    = reg_we;
    assign bus.in_ack    = in_ack;
    assign bus.out_valid = out_valid;
    assign bus.halted    = halted;
    assign bus.io_err    = io_err_reg;
    assign bus.state     = state_reg;
endmodule
